// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slv_state_t;

    // Little-endian lane enables for a legal (aligned) access.
    function automatic logic [3:0] byte_en(input logic [2:0] size,
                                           input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        if (size == HSIZE_BYTE) begin
            be = 4'b0001 << off;
        end else if (size == HSIZE_HALF) begin
            be = off[1] ? 4'b1100 : 4'b0011;
        end
        return be;
    endfunction

endpackage

// File: rtl/ahb_be_ram.sv
// Word-wide RAM with per-byte synchronous write enables and
// asynchronous read; contents are never reset.
module ahb_be_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i && be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: wait states, byte lanes and two-cycle
// ERROR for misaligned, oversized or out-of-range transfers.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    input  logic                  Hsel,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [1:0]            Htrans,
    input  logic                  Hwrite,
    input  logic [2:0]            Hsize,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    input  logic                  Hready,
    output logic [DATA_WIDTH-1:0] Hrdata,
    output logic                  Hreadyout,
    output logic [1:0]            Hresp
);

    localparam int         AW = $clog2(MEM_DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    slv_state_t    state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] idx_q;
    logic          write_q;
    logic [3:0]    be_q;
    logic          ready_q;
    logic [1:0]    resp_q;

    logic        accept;
    logic        bad;
    logic        we;
    logic [31:0] rdata;

    assign accept = Hsel && Hready && ready_q &&
                    (Htrans == HTRANS_NONSEQ || Htrans == HTRANS_SEQ);

    // Range is judged on the full address so aliases above the array fault.
    assign bad = (Hsize > HSIZE_WORD) ||
                 (Hsize == HSIZE_HALF && Haddr[0]) ||
                 (Hsize == HSIZE_WORD && Haddr[1:0] != 2'b00) ||
                 (|Haddr[ADDR_WIDTH-1:AW+2]);

    assign we = (state_q == ST_DATA) && (cnt_q == 4'd0) && write_q;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            be_q    <= 4'b0000;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
        end else if (state_q == ST_ERR1) begin
            state_q <= ST_ERR2;
            ready_q <= 1'b1;
        end else if (!ready_q) begin
            cnt_q   <= cnt_q - 4'd1;
            ready_q <= (cnt_q == 4'd1);
        end else if (accept && bad) begin
            state_q <= ST_ERR1;
            ready_q <= 1'b0;
            resp_q  <= HRESP_ERROR;
            write_q <= 1'b0;
        end else if (accept) begin
            state_q <= ST_DATA;
            cnt_q   <= WS;
            ready_q <= (WS == 4'd0);
            resp_q  <= HRESP_OKAY;
            idx_q   <= Haddr[AW+1:2];
            write_q <= Hwrite;
            be_q    <= byte_en(Hsize, Haddr[1:0]);
        end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
        end
    end

    ahb_be_ram #(
        .DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk_i   (Hclk),
        .we_i    (we),
        .be_i    (be_q),
        .addr_i  (idx_q),
        .wdata_i (Hwdata),
        .rdata_o (rdata)
    );

    assign Hrdata    = (state_q == ST_DATA && !write_q) ? rdata : '0;
    assign Hreadyout = ready_q;
    assign Hresp     = resp_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances (0/3/5 wait
// states) on one bus, responses checked from a scoreboard queue.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    logic        Hclk = 1'b0;
    logic        Hresetn = 1'b0;
    logic        Hsel = 1'b0;
    logic [31:0] Haddr = '0;
    logic [1:0]  Htrans = 2'b00;
    logic        Hwrite = 1'b0;
    logic [2:0]  Hsize = 3'b010;
    logic [31:0] Hwdata = '0;
    logic        Hready;
    int          cur = 0;

    logic        ro0, ro1, ro2;
    logic [1:0]  rs0, rs1, rs2;
    logic [31:0] rd0, rd1, rd2;
    logic [1:0]  mresp;
    logic [31:0] mrdata;

    always #5 Hclk = ~Hclk;

    assign Hready = (cur == 0) ? ro0 : (cur == 1) ? ro1 : ro2;
    assign mresp  = (cur == 0) ? rs0 : (cur == 1) ? rs1 : rs2;
    assign mrdata = (cur == 0) ? rd0 : (cur == 1) ? rd1 : rd2;

    ahb_sram_slave #(.WAIT_STATES(0)) u0 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(Hsel && cur == 0),
        .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize),
        .Hwdata(Hwdata), .Hready(Hready), .Hrdata(rd0),
        .Hreadyout(ro0), .Hresp(rs0));

    ahb_sram_slave #(.WAIT_STATES(3)) u1 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(Hsel && cur == 1),
        .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize),
        .Hwdata(Hwdata), .Hready(Hready), .Hrdata(rd1),
        .Hreadyout(ro1), .Hresp(rs1));

    ahb_sram_slave #(.WAIT_STATES(5)) u2 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(Hsel && cur == 2),
        .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize),
        .Hwdata(Hwdata), .Hready(Hready), .Hrdata(rd2),
        .Hreadyout(ro2), .Hresp(rs2));

    typedef struct {
        string       tag;
        logic [1:0]  resp;
        int          waits;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   lowcnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    function automatic int ws_of(input int c);
        return (c == 0) ? 0 : (c == 1) ? 3 : 5;
    endfunction

    // Drive an address phase, wait for acceptance, record expectation.
    task automatic issue(input string tag, input bit w,
                         input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] d, input bit err,
                         input logic [31:0] rexp);
        exp_t e;
        int   n;
        n = 0;
        Hsel = 1'b1;
        Haddr = a;
        Htrans = 2'b10;
        Hwrite = w;
        Hsize = sz;
        while (!Hready && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_accept"}, 32'(Hready), 32'd1);
        tick();
        e.tag = tag;
        e.resp = err ? HRESP_ERROR : HRESP_OKAY;
        e.waits = err ? 1 : ws_of(cur);
        e.rdata = (w || err) ? 32'h0 : rexp;
        q.push_back(e);
        Hwdata = d;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        Htrans = 2'b00;
        Hsel = 1'b0;
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_drain"}, 32'(q.size()), 32'd0);
        tick();
    endtask

    // Data-phase monitor: counts low-ready cycles, checks on completion.
    always @(negedge Hclk) begin
        if (q.size() == 0) begin
            lowcnt = 0;
        end else if (!Hready) begin
            lowcnt++;
        end else begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, "_resp"}, 32'(mresp), 32'(e.resp));
            chk({e.tag, "_waits"}, 32'(lowcnt), 32'(e.waits));
            chk({e.tag, "_rdata"}, mrdata, e.rdata);
            lowcnt = 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cur = 0;
        repeat (2) @(posedge Hclk);
        #1;
        chk("rst_ready", 32'(ro0), 32'd1);
        chk("rst_resp", 32'(rs0), 32'd0);
        chk("rst_rdata", rd0, 32'h0);
        Hresetn = 1'b1;
        tick();

        // Back-to-back write then read, zero wait
        issue("w10", 1, 32'h10, HSIZE_WORD, 32'hA5A55A5A, 0, 0);
        issue("r10", 0, 32'h10, HSIZE_WORD, 32'h0, 0, 32'hA5A55A5A);
        drain("raw");

        // Byte and halfword lanes
        issue("w0", 1, 32'h0, HSIZE_WORD, 32'h00000000, 0, 0);
        issue("b1", 1, 32'h1, HSIZE_BYTE, 32'hCCCC11CC, 0, 0);
        issue("h2", 1, 32'h2, HSIZE_HALF, 32'hBEEF3333, 0, 0);
        issue("r0", 0, 32'h0, HSIZE_WORD, 32'h0, 0, 32'hBEEF1100);
        drain("lanes");

        // Error responses leave memory untouched
        issue("w4", 1, 32'h4, HSIZE_WORD, 32'hCAFEF00D, 0, 0);
        issue("e_w6", 1, 32'h6, HSIZE_WORD, 32'hFFFFFFFF, 1, 0);
        issue("e_h1", 1, 32'h1, HSIZE_HALF, 32'hFFFFFFFF, 1, 0);
        issue("e_sz", 1, 32'h4, 3'b011, 32'hFFFFFFFF, 1, 0);
        issue("r4", 0, 32'h4, HSIZE_WORD, 32'h0, 0, 32'hCAFEF00D);
        issue("r0b", 0, 32'h0, HSIZE_WORD, 32'h0, 0, 32'hBEEF1100);
        drain("err");

        // Range boundary, including an alias of word 0
        issue("e_400", 1, 32'h400, HSIZE_WORD, 32'hFFFFFFFF, 1, 0);
        issue("w3fc", 1, 32'h3FC, HSIZE_WORD, 32'h0BADF00D, 0, 0);
        issue("r3fc", 0, 32'h3FC, HSIZE_WORD, 32'h0, 0, 32'h0BADF00D);
        issue("e_hi", 1, 32'h10000000, HSIZE_WORD, 32'hFFFFFFFF, 1, 0);
        issue("r0c", 0, 32'h0, HSIZE_WORD, 32'h0, 0, 32'hBEEF1100);
        drain("range");

        // BUSY while selected: zero-wait OKAY, no write
        Hsel = 1'b1;
        Haddr = 32'h0;
        Htrans = 2'b01;
        Hwrite = 1'b1;
        Hsize = HSIZE_WORD;
        Hwdata = 32'hFFFFFFFF;
        tick();
        chk("busy_ready", 32'(ro0), 32'd1);
        chk("busy_resp", 32'(rs0), 32'd0);
        tick();
        tick();
        drain("busy");
        issue("r0d", 0, 32'h0, HSIZE_WORD, 32'h0, 0, 32'hBEEF1100);
        drain("busy_rd");

        // Three wait states, pipelined
        cur = 1;
        issue("ws_w10", 1, 32'h10, HSIZE_WORD, 32'h01020304, 0, 0);
        issue("ws_w20", 1, 32'h20, HSIZE_WORD, 32'h5555AAAA, 0, 0);
        issue("ws_r20", 0, 32'h20, HSIZE_WORD, 32'h0, 0, 32'h5555AAAA);
        issue("ws_r10", 0, 32'h10, HSIZE_WORD, 32'h0, 0, 32'h01020304);
        issue("ws_e22", 0, 32'h22, HSIZE_WORD, 32'h0, 1, 0);
        drain("ws");

        // Reset in the middle of a five-wait write
        cur = 2;
        issue("rs_w8", 1, 32'h8, HSIZE_WORD, 32'h76543210, 0, 0);
        drain("rs_pre");
        issue("rs_wff", 1, 32'h8, HSIZE_WORD, 32'hFFFFFFFF, 0, 0);
        Htrans = 2'b00;
        Hsel = 1'b0;
        tick();
        tick();
        chk("mid_ready", 32'(ro2), 32'd0);
        #1;
        Hresetn = 1'b0;
        q.delete();
        #1;
        chk("arst_ready", 32'(ro2), 32'd1);
        chk("arst_resp", 32'(rs2), 32'd0);
        chk("arst_rdata", rd2, 32'h0);
        tick();
        Hresetn = 1'b1;
        tick();
        issue("rs_r8", 0, 32'h8, HSIZE_WORD, 32'h0, 0, 32'h76543210);
        drain("rs_post");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
AHB-Lite memory responder: one instance per slave port, driving Hrdata_S/Hresp_S/Hreadyout_S into the slave-to-master response mux.
- Captures address-phase controls, applies a configurable number of wait states, then completes reads and writes against an internal word array.
- Unaligned, oversized or out-of-range accesses get the two-cycle AHB ERROR response.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 is supported.
ADDR_WIDTH, 32, Haddr width.
MEM_DEPTH, 256, number of 32-bit words; must be a power of two.
WAIT_STATES, 0, Hreadyout-low cycles per OKAY transfer; legal range 0..15.

Ports:
Hclk  in  1  bus clock.
Hresetn  in  1  reset.
Hsel  in  1  slave select from the decoder.
Haddr  in  ADDR_WIDTH  byte address; offset within the slave is Haddr[$clog2(MEM_DEPTH)+1:0].
Htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
Hwrite  in  1  1 = write.
Hsize  in  3  000 byte, 001 halfword, 010 word.
Hwdata  in  DATA_WIDTH  write data, valid in the data phase.
Hready  in  1  global Hready from the response mux.
Hrdata  out  DATA_WIDTH  read data.
Hreadyout  out  1  slave ready.
Hresp  out  2  00 OKAY, 01 ERROR.

Behaviour:
- Clock and reset: clock Hclk; reset Hresetn, asynchronous, active-low.
- Reset values: Hreadyout=1, Hresp=00, Hrdata=0, FSM in IDLE, wait counter=0. Memory contents are not cleared.
- Transfer acceptance: a transfer is accepted on a rising edge where Hsel & Hready & Htrans[1].
  - On acceptance, register address, Hwrite and Hsize.
  - Anything else (IDLE, BUSY, not selected) gets a zero-wait OKAY data phase.
- Error check (evaluated at acceptance):
  - Hsize > 010.
  - Halfword with Haddr[0] = 1.
  - Word with Haddr[1:0] != 00.
  - Word index Haddr[ADDR_WIDTH-1:2] >= MEM_DEPTH, compared on the full address, not the truncated offset.
- FSM states: IDLE, DATA, ERR1, ERR2.
- IDLE:
  - Hreadyout=1, Hresp=00.
  - Accepted legal transfer -> DATA with counter = WAIT_STATES.
  - Accepted illegal transfer -> ERR1.
- DATA:
  - While counter != 0: Hreadyout=0, counter decrements.
  - At counter = 0: Hreadyout=1, Hresp=00, transfer completes.
  - Pipelining: on the completing cycle a new address phase can be accepted on the same edge; next state is DATA, ERR1 or IDLE accordingly, with no bubble.
- ERR1: Hreadyout=0, Hresp=01 -> ERR2.
- ERR2:
  - Hreadyout=1, Hresp=01.
  - A new address phase can be accepted on this edge.
  - An errored transfer never writes memory.
- Writes:
  - Committed on the completing edge of DATA.
  - Byte lanes are little-endian: byte writes lane Haddr[1:0]; halfword writes lanes {a+1,a} for a = Haddr[1:0] in {0,2}; word writes all four lanes.
- Reads:
  - Hrdata = mem[word index] combinationally from the registered index.
  - The full 32-bit word is returned regardless of Hsize; the master extracts its lanes.
  - Hrdata is valid whenever the FSM is in DATA.
  - Hrdata = 0 in IDLE, ERR1, ERR2 and for write data phases.
- Read-after-write: a read issued immediately after a write to the same word returns the new data, because the write commits on the edge that starts the read data phase.
- Hsel dropping mid-data-phase has no effect; the data phase completes.
- Asynchronous reset mid-transfer aborts it: no partial write, outputs return to reset values.

Decomposition:
- Package ahb_pkg holds:
  - htrans_t enum (IDLE/BUSY/NONSEQ/SEQ).
  - hsize constants (BYTE/HALF/WORD).
  - HRESP_OKAY and HRESP_ERROR.
  - The slave FSM state enum.
- One natural sub-module: ahb_be_ram, a MEM_DEPTH x 32 array with 4-bit byte-enable synchronous write and asynchronous read.

Test Plan:
- Zero-wait word write then read: WAIT_STATES=0, write 0xA5A55A5A to 0x10, then read 0x10 back-to-back -> Hreadyout stays 1, Hresp=00, read phase Hrdata=0xA5A55A5A.
- Wait states: WAIT_STATES=3, word read of 0x20 -> Hreadyout low for exactly 3 cycles, high on the 4th with data; next NONSEQ is accepted on that edge.
- Byte and halfword writes: word 0x0 preloaded 0x00000000; byte 0x11 to 0x1, halfword 0xBEEF to 0x2; word read -> Hrdata=0xBEEF1100.
- Errors: word access to 0x6, halfword to 0x1, and Hsize=011 each -> Hresp=01 with Hreadyout 0 then 1; memory unchanged on readback.
- Out of range: MEM_DEPTH=256, access to 0x400 -> two-cycle ERROR; access to 0x3FC -> OKAY.
- IDLE/BUSY and reset: Htrans=01 with Hsel=1 -> zero-wait OKAY and no write. Assert Hresetn mid-wait (WAIT_STATES=5, write of 0xFFFFFFFF) -> Hreadyout=1, Hresp=00, Hrdata=0 immediately, and the target word still holds its old value.
